// File: rtl/fmap_pingpong_buffer_pkg.sv
// Shared constants for the feature-map ping-pong buffer and its storage banks.
// Pure constants and types; no logic.
package fmap_pingpong_buffer_pkg;
  localparam int DATA_W       = 8;
  localparam int DEPTH_DEF    = 676;
  localparam int ADDR_LEN_DEF = 9;
  localparam int NUM_BANKS    = 2;

  typedef logic [1:0] fill_cnt_t;
endpackage

// File: rtl/fmap_pingpong_buffer_if.sv
// Write/read bus between the convolution engine, the buffer and the downstream reader.
// master drives strobes and addresses, slave (the buffer) returns status and read data.
interface fmap_pingpong_buffer_if
  import fmap_pingpong_buffer_pkg::*;
#(
  parameter int ADDR_LEN = ADDR_LEN_DEF
);
  logic                     wr_store;
  logic [ADDR_LEN:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     wr_done;
  logic                     wr_ready;
  logic [ADDR_LEN:0]        rd_addr1;
  logic [ADDR_LEN:0]        rd_addr2;
  logic signed [DATA_W-1:0] rd_data1;
  logic signed [DATA_W-1:0] rd_data2;
  logic                     rd_valid;
  logic                     rd_release;
  logic                     err;

  modport master (
    output wr_store, wr_addr, wr_data, wr_done, rd_addr1, rd_addr2, rd_release,
    input  wr_ready, rd_data1, rd_data2, rd_valid, err
  );

  modport slave (
    input  wr_store, wr_addr, wr_data, wr_done, rd_addr1, rd_addr2, rd_release,
    output wr_ready, rd_data1, rd_data2, rd_valid, err
  );
endinterface

// File: rtl/fmap_pingpong_buffer_bank.sv
// One DEPTH x 8 storage bank: one synchronous write port, two registered read ports (1-cycle).
// No reset on storage or read registers so the array maps onto block RAM.
module fmap_bank
  import fmap_pingpong_buffer_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [ADDR_LEN:0]        waddr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  input  logic [ADDR_LEN:0]        raddr1_i,
  input  logic [ADDR_LEN:0]        raddr2_i,
  output logic signed [DATA_W-1:0] rdata1_o,
  output logic signed [DATA_W-1:0] rdata2_o
);
  localparam logic [ADDR_LEN:0] DEPTH_A = (ADDR_LEN+1)'(DEPTH);

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic signed [DATA_W-1:0] rdata1_q;
  logic signed [DATA_W-1:0] rdata2_q;

  // Out-of-range read addresses are folded to 0; the top level zeroes that data anyway.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata1_q <= mem_q[(raddr1_i < DEPTH_A) ? raddr1_i : '0];
    rdata2_q <= mem_q[(raddr2_i < DEPTH_A) ? raddr2_i : '0];
  end

  assign rdata1_o = rdata1_q;
  assign rdata2_o = rdata2_q;
endmodule

// File: rtl/fmap_pingpong_buffer.sv
// Two-bank ping-pong feature-map buffer; reads return data one cycle after the address.
// wr_ready drops when both banks hold completed maps; misuse is dropped and flagged on sticky err.
module fmap_pingpong_buffer
  import fmap_pingpong_buffer_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  fmap_pingpong_buffer_if.slave bus
);
  localparam logic [ADDR_LEN:0] DEPTH_A = (ADDR_LEN+1)'(DEPTH);

  logic      wp_q, wp_d;
  logic      rp_q, rp_d;
  fill_cnt_t cnt_q, cnt_d;
  logic      err_q, err_d;
  logic      sel_q, sel_d;
  logic      zero1_q, zero1_d;
  logic      zero2_q, zero2_d;

  logic      wr_ready, rd_valid;
  logic      wr_ok, done_ok, rel_ok;

  logic signed [DATA_W-1:0] bank_rd1 [NUM_BANKS];
  logic signed [DATA_W-1:0] bank_rd2 [NUM_BANKS];

  assign wr_ready = (cnt_q != 2'd2);
  assign rd_valid = (cnt_q != 2'd0);

  always_comb begin
    wr_ok   = bus.wr_store & wr_ready & (bus.wr_addr < DEPTH_A);
    done_ok = bus.wr_done & wr_ready;
    rel_ok  = bus.rd_release & rd_valid;

    wp_d  = wp_q ^ done_ok;
    rp_d  = rp_q ^ rel_ok;
    cnt_d = cnt_q + fill_cnt_t'(done_ok) - fill_cnt_t'(rel_ok);
    err_d = err_q
          | (bus.wr_store & ~wr_ok)
          | (bus.wr_done & ~wr_ready)
          | (bus.rd_release & ~rd_valid);

    // Remember which bank and whether to blank, as seen at the address-sampling edge.
    sel_d   = rp_q;
    zero1_d = ~rd_valid | (bus.rd_addr1 >= DEPTH_A);
    zero2_d = ~rd_valid | (bus.rd_addr2 >= DEPTH_A);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      zero1_q <= 1'b1;
      zero2_q <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      zero1_q <= zero1_d;
      zero2_q <= zero2_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    fmap_bank #(
      .DEPTH    (DEPTH),
      .ADDR_LEN (ADDR_LEN)
    ) u_bank (
      .clk      (clk),
      .we_i     (wr_ok & (wp_q == b[0])),
      .waddr_i  (bus.wr_addr),
      .wdata_i  (bus.wr_data),
      .raddr1_i (bus.rd_addr1),
      .raddr2_i (bus.rd_addr2),
      .rdata1_o (bank_rd1[b]),
      .rdata2_o (bank_rd2[b])
    );
  end

  assign bus.rd_data1 = zero1_q ? '0 : bank_rd1[sel_q];
  assign bus.rd_data2 = zero2_q ? '0 : bank_rd2[sel_q];
  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = rd_valid;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_fmap_pingpong_buffer.sv
// Bench for fmap_pingpong_buffer: vector table, directed corner sequences, then random traffic
// compared against a queue-of-completed-banks reference model.
module tb_fmap_pingpong_buffer;
  localparam int D = 676;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fmap_pingpong_buffer_if #(.ADDR_LEN(9)) bus ();

  fmap_pingpong_buffer #(.DEPTH(D), .ADDR_LEN(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: contents of both banks, the bank being filled, and the
  // ordered list of completed banks awaiting the reader.
  logic [7:0] m_mem [2][D];
  int         m_wp;
  int         m_done_q[$];
  logic       m_err;
  logic [7:0] m_d1, m_d2;

  typedef struct {
    logic       st;
    logic [9:0] wa;
    logic [7:0] wd;
    logic       dn;
    logic [9:0] a1;
    logic [9:0] a2;
    logic       rel;
    logic       ev;
    logic       er;
    logic       ee;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wp = 0;
    m_done_q.delete();
    m_err = 1'b0;
    m_d1 = 8'h00;
    m_d2 = 8'h00;
  endtask

  task automatic model_step(input logic st, input logic [9:0] wa, input logic [7:0] wd,
                            input logic dn, input logic [9:0] a1, input logic [9:0] a2,
                            input logic rel);
    bit v, r;
    int rb;
    v  = (m_done_q.size() > 0);
    r  = (m_done_q.size() < 2);
    rb = v ? m_done_q[0] : 0;
    m_d1 = (v && a1 < 10'(D)) ? m_mem[rb][a1] : 8'h00;
    m_d2 = (v && a2 < 10'(D)) ? m_mem[rb][a2] : 8'h00;
    if (st) begin
      if (r && wa < 10'(D)) m_mem[m_wp][wa] = wd;
      else m_err = 1'b1;
    end
    if (rel) begin
      if (v) void'(m_done_q.pop_front());
      else m_err = 1'b1;
    end
    if (dn) begin
      if (r) begin
        m_done_q.push_back(m_wp);
        m_wp = 1 - m_wp;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic apply(input logic st, input logic [9:0] wa, input logic [7:0] wd,
                       input logic dn, input logic [9:0] a1, input logic [9:0] a2,
                       input logic rel);
    bus.wr_store   = st;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.wr_done    = dn;
    bus.rd_addr1   = a1;
    bus.rd_addr2   = a2;
    bus.rd_release = rel;
    model_step(st, wa, wd, dn, a1, a2, rel);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 10'd0, 1'b0);
  endtask

  task automatic check_model();
    check("rd_valid", {7'b0, bus.rd_valid}, {7'b0, m_done_q.size() > 0});
    check("wr_ready", {7'b0, bus.wr_ready}, {7'b0, m_done_q.size() < 2});
    check("err",      {7'b0, bus.err},      {7'b0, m_err});
    check("rd_data1", bus.rd_data1, m_d1);
    check("rd_data2", bus.rd_data2, m_d2);
  endtask

  task automatic do_reset();
    bus.wr_store   = 1'b0;
    bus.wr_done    = 1'b0;
    bus.rd_release = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_rd_valid", {7'b0, bus.rd_valid}, 8'd0);
    check("rst_wr_ready", {7'b0, bus.wr_ready}, 8'd1);
    check("rst_err",      {7'b0, bus.err},      8'd0);
    check("rst_rd_data1", bus.rd_data1, 8'h00);
    check("rst_rd_data2", bus.rd_data2, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < D; a++) m_mem[b][a] = 8'h00;

    //           st  wa       wd     dn  a1       a2      rel  ev  er  ee  e1     e2
    tbl[0] = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 10'd3,   8'h11, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[2] = '{1'b1, 10'd4,   8'hFB, 1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[3] = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd3, 10'd4, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'hFB};
    tbl[4] = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd4, 10'd4, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFB, 8'hFB};
    tbl[5] = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd3, 10'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[6] = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00};
    tbl[7] = '{1'b1, 10'd676, 8'h5A, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00};
    tbl[8] = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00};

    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].st, tbl[i].wa, tbl[i].wd, tbl[i].dn, tbl[i].a1, tbl[i].a2, tbl[i].rel);
      check($sformatf("vec%0d_rd_valid", i), {7'b0, bus.rd_valid}, {7'b0, tbl[i].ev});
      check($sformatf("vec%0d_wr_ready", i), {7'b0, bus.wr_ready}, {7'b0, tbl[i].er});
      check($sformatf("vec%0d_err", i),      {7'b0, bus.err},      {7'b0, tbl[i].ee});
      check($sformatf("vec%0d_rd_data1", i), bus.rd_data1, tbl[i].e1);
      check($sformatf("vec%0d_rd_data2", i), bus.rd_data2, tbl[i].e2);
    end

    // Fill bank 0 with addr[7:0], complete it, read two words.
    do_reset();
    for (int a = 0; a < D; a++) begin
      apply(1'b1, 10'(a), 8'(a), 1'b0, 10'd0, 10'd0, 1'b0);
      check_model();
    end
    apply(1'b0, 10'd0, 8'h00, 1'b1, 10'd0, 10'd0, 1'b0);
    check("fill0_rd_valid", {7'b0, bus.rd_valid}, 8'd1);
    check("fill0_wr_ready", {7'b0, bus.wr_ready}, 8'd1);
    apply(1'b0, 10'd0, 8'h00, 1'b0, 10'd5, 10'd675, 1'b0);
    check("rd5", bus.rd_data1, 8'h05);
    check("rd675", bus.rd_data2, 8'hA3);

    // Fill bank 1 with 7F; both full, further write is an error and changes nothing.
    for (int a = 0; a < D; a++) apply(1'b1, 10'(a), 8'h7F, 1'b0, 10'd0, 10'd0, 1'b0);
    apply(1'b0, 10'd0, 8'h00, 1'b1, 10'd0, 10'd0, 1'b0);
    check("full_wr_ready", {7'b0, bus.wr_ready}, 8'd0);
    apply(1'b1, 10'd10, 8'h55, 1'b0, 10'd0, 10'd0, 1'b0);
    check("full_store_err", {7'b0, bus.err}, 8'd1);
    apply(1'b0, 10'd0, 8'h00, 1'b0, 10'd10, 10'd0, 1'b0);
    check("bank0_kept", bus.rd_data1, 8'h0A);
    check_model();
    apply(1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 10'd10, 1'b1);
    check_model();
    apply(1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 10'd10, 1'b0);
    check("bank1_rd0", bus.rd_data1, 8'h7F);
    check("bank1_kept", bus.rd_data2, 8'h7F);

    // Done and release together with one bank full: count stays 1, both pointers flip.
    apply(1'b0, 10'd0, 8'h00, 1'b1, 10'd0, 10'd0, 1'b1);
    check("swap_rd_valid", {7'b0, bus.rd_valid}, 8'd1);
    check("swap_wr_ready", {7'b0, bus.wr_ready}, 8'd1);
    apply(1'b0, 10'd0, 8'h00, 1'b0, 10'd5, 10'd0, 1'b0);
    check("swap_rd5", bus.rd_data1, 8'h05);
    check_model();

    // Release with nothing to read.
    do_reset();
    apply(1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 10'd0, 1'b1);
    check("empty_rel_err", {7'b0, bus.err}, 8'd1);
    check("empty_rel_valid", {7'b0, bus.rd_valid}, 8'd0);

    // Out-of-range write and read.
    do_reset();
    apply(1'b1, 10'd676, 8'h99, 1'b0, 10'd0, 10'd0, 1'b0);
    check("oor_wr_err", {7'b0, bus.err}, 8'd1);
    apply(1'b0, 10'd0, 8'h00, 1'b1, 10'd0, 10'd0, 1'b0);
    apply(1'b0, 10'd0, 8'h00, 1'b0, 10'd700, 10'd5, 1'b0);
    check("oor_rd700", bus.rd_data1, 8'h00);
    check("oor_rd5", bus.rd_data2, 8'h05);

    // Asynchronous reset between edges with both banks full.
    apply(1'b0, 10'd0, 8'h00, 1'b1, 10'd0, 10'd0, 1'b0);
    apply(1'b0, 10'd0, 8'h00, 1'b0, 10'd5, 10'd5, 1'b0);
    check("pre_arst_rd5", bus.rd_data1, 8'h05);
    check("pre_arst_ready", {7'b0, bus.wr_ready}, 8'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rd_valid", {7'b0, bus.rd_valid}, 8'd0);
    check("arst_wr_ready", {7'b0, bus.wr_ready}, 8'd1);
    check("arst_rd_data1", bus.rd_data1, 8'h00);
    check("arst_err", {7'b0, bus.err}, 8'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First write after reset lands in bank 0.
    apply(1'b1, 10'd7, 8'h33, 1'b1, 10'd0, 10'd0, 1'b0);
    apply(1'b0, 10'd0, 8'h00, 1'b0, 10'd7, 10'd7, 1'b0);
    check("post_rst_bank0", bus.rd_data1, 8'h33);
    check_model();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic       st, dn, rel;
      logic [9:0] wa, a1, a2;
      st  = ($urandom_range(0, 99) < 60);
      dn  = ($urandom_range(0, 99) < 4);
      rel = ($urandom_range(0, 99) < 4);
      wa  = ($urandom_range(0, 99) < 3) ? 10'($urandom_range(676, 1023)) : 10'($urandom_range(0, D - 1));
      a1  = 10'($urandom_range(0, 720));
      a2  = ($urandom_range(0, 9) == 0) ? a1 : 10'($urandom_range(0, 720));
      apply(st, wa, 8'($urandom), dn, a1, a2, rel);
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fmap_pingpong_buffer.md
FMAP_PINGPONG_BUFFER -- requirements
Module: fmap_pingpong_buffer

Interface
REQ-001 Parameter DEPTH, default 676, number of 8-bit words per bank (26x26 output map).
REQ-002 Parameter ADDR_LEN, default 9; all address ports are ADDR_LEN+1 bits wide.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 wr_store  input  1  write strobe from the convolution engine; one word per cycle when high.
REQ-006 wr_addr  input  ADDR_LEN+1  write word address within the current write bank.
REQ-007 wr_data  input  8 signed  write word.
REQ-008 wr_done  input  1  single-cycle pulse; the current write bank is complete.
REQ-009 wr_ready  output  1  a bank is available for writing.
REQ-010 rd_addr1  input  ADDR_LEN+1  read port 1 address.
REQ-011 rd_addr2  input  ADDR_LEN+1  read port 2 address.
REQ-012 rd_data1  output  8 signed  read port 1 data.
REQ-013 rd_data2  output  8 signed  read port 2 data.
REQ-014 rd_valid  output  1  a completed bank is available for reading.
REQ-015 rd_release  input  1  single-cycle pulse; the reader has finished with the current read bank.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 The block SHALL hold two banks; the write pointer wp selects the write bank and the read pointer rp selects the read bank.
REQ-018 The block SHALL keep full_cnt (0..2); wr_ready = (full_cnt < 2); rd_valid = (full_cnt > 0); both outputs combinational from registers.
REQ-019 The write is accepted when wr_store & wr_ready & wr_addr < DEPTH; the word is written to bank wp at wr_addr at that rising edge.
REQ-020 wr_store with wr_ready low or wr_addr >= DEPTH SHALL drop the write and set err.
REQ-021 wr_done with wr_ready high SHALL toggle wp and increment full_cnt; wr_done with wr_ready low SHALL be ignored and set err.
REQ-022 rd_release with rd_valid high SHALL toggle rp and decrement full_cnt; rd_release with rd_valid low SHALL be ignored and set err.
REQ-023 Accepted wr_done and rd_release in the same cycle SHALL toggle both pointers and leave full_cnt unchanged.
REQ-024 wr_store and wr_done in the same cycle SHALL write the word into the old bank wp before the toggle.
REQ-025 The read ports SHALL be registered, with 1-cycle latency: rd_dataN at edge k+1 = bank rp word at rd_addrN sampled at edge k.
REQ-026 The read data SHALL be 0 when rd_valid was low or rd_addrN >= DEPTH at the sampling edge.
REQ-027 Both read ports SHALL be independent, and equal addresses SHALL return equal data.
REQ-028 A read of the bank being written is impossible by construction (wp != rp whenever rd_valid & wr_ready); no bypass is required.
REQ-029 err SHALL remain set until reset.

Reset
REQ-030 rst high SHALL force wp=0, rp=0, full_cnt=0, rd_data1=rd_data2=0, err=0 immediately, without waiting for a clock edge.
REQ-031 Bank contents SHALL NOT be reset; assertion mid-frame discards both banks logically (rd_valid=0, wr_ready=1).
REQ-032 After rst deasserts, the first accepted write SHALL go to bank 0.

Structure
REQ-033 The shared package SHALL hold DATA_W=8, the DEPTH and ADDR_LEN defaults, and the NUM_BANKS=2 constant.
REQ-034 There SHALL be one sub-module, fmap_bank: one synchronous write port and two registered read ports, with DEPTH x 8 inferable as block RAM.
REQ-035 fmap_bank SHALL be instantiated twice; the top level SHALL hold the pointers, the counter, the error logic and the read-data mux/zeroing.

Verification
REQ-036 Reset, write addr 0..675 with data=addr[7:0], wr_done -> rd_valid=1, wr_ready=1; rd_addr1=5, rd_addr2=675 -> next cycle rd_data1=5, rd_data2=8'hA3.
REQ-037 Fill bank 0, wr_done, fill bank 1 with 8'h7F, wr_done -> wr_ready=0; then wr_store -> err=1 and both banks unchanged.
REQ-038 Two full banks, rd_release -> rp=1, rd_addr1=0 returns 8'h7F; wr_done and rd_release in the same cycle with full_cnt=1 -> full_cnt stays 1.
REQ-039 wr_store at wr_addr=676 -> write dropped, err=1; rd_addr1=700 with rd_valid=1 -> rd_data1=0.
REQ-040 Assert rst asynchronously between edges while full_cnt=2 -> rd_valid=0, wr_ready=1, rd_data1=0 before the next edge.
REQ-041 rd_release with rd_valid=0 -> full_cnt stays 0, err=1.
